video_pattern_gen: RTL and testbench

Source side of the 10-bit 4:2:2 `{luma, chroma}` + `fvht` video interface consumed by the video processing blocks. Generates a 1080-line progressive raster with timing flags and one of three test patterns: 75% colour bars, flat colour, luma ramp. Its `video_o`/`fvht_o` connect directly to a downstream block's `vdat_*_i`/`fvht_i`.

---
 rtl/video_pkg.sv | 47 ++++
 rtl/video_timing_if.sv | 18 +
 rtl/video_timing_cnt.sv | 65 ++++++
 rtl/video_pattern_gen.sv | 106 ++++++++++
 tb/tb_video_pattern_gen.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/video_pkg.sv
// Shared constants and types for the 10-bit 4:2:2 test pattern source.
// LUT order is white, yellow, cyan, green, magenta, red, blue, black.
package video_pkg;

  localparam int F_BIT = 3;
  localparam int V_BIT = 2;
  localparam int H_BIT = 1;
  localparam int T_BIT = 0;

  localparam logic [9:0] Y_BLANK = 10'd64;
  localparam logic [9:0] C_BLANK = 10'd512;
  localparam logic [10:0] RAMP_MAX = 11'd940;

  // Packed with index 7 leftmost so that LUT[idx] picks colour idx.
  localparam logic [7:0][9:0] Y_LUT = {
    10'd64, 10'd139, 10'd260, 10'd335,
    10'd450, 10'd525, 10'd646, 10'd940
  };
  localparam logic [7:0][9:0] CB_LUT = {
    10'd512, 10'd848, 10'd399, 10'd735,
    10'd289, 10'd625, 10'd176, 10'd512
  };
  localparam logic [7:0][9:0] CR_LUT = {
    10'd512, 10'd457, 10'd848, 10'd793,
    10'd231, 10'd176, 10'd567, 10'd512
  };

  typedef enum logic [1:0] {
    PAT_BARS = 2'd0,
    PAT_FLAT = 2'd1,
    PAT_RAMP = 2'd2
  } pat_sel_e;

  function automatic pat_sel_e decode_pat(
    input logic [1:0] sel
  );
    pat_sel_e p;
    p = PAT_BARS;
    unique case (sel)
      2'd1:    p = PAT_FLAT;
      2'd2:    p = PAT_RAMP;
      default: p = PAT_BARS;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/video_timing_if.sv
// Raster position and timing decode handed from the
// counter block to the pattern datapath.
interface video_timing_if;
  logic [11:0] h_cnt;
  logic        active;
  logic        frame_start;
  logic        sof;
  logic [3:0]  fvht;

  modport master (
    output h_cnt, active, frame_start,
    output sof, fvht
  );
  modport slave (
    input h_cnt, active, frame_start,
    input sof, fvht
  );
endinterface

// File: rtl/video_timing_cnt.sv
// Raster counters and fvht/active/sof decode.
// All decode is combinational on the current counter state.
module video_timing_cnt
  import video_pkg::*;
#(
  parameter int H_ACTIVE = 1920,
  parameter int H_TOTAL  = 2200,
  parameter int V_TOTAL  = 1125,
  parameter int V_START  = 41,
  parameter int V_ACTIVE = 1080
) (
  input  logic           clk_i,
  input  logic           rst_n_i,
  input  logic           cen_i,
  video_timing_if.master tim
);

  localparam logic [11:0] HA  = 12'(H_ACTIVE);
  localparam logic [11:0] HT1 = 12'(H_TOTAL - 1);
  localparam logic [11:0] VT1 = 12'(V_TOTAL - 1);
  localparam logic [11:0] VS  = 12'(V_START);
  localparam logic [11:0] VE  = 12'(V_START + V_ACTIVE);
  localparam logic [11:0] EAV_END = 12'(H_ACTIVE + 3);
  localparam logic [11:0] SAV_BEG = 12'(H_TOTAL - 4);

  logic [11:0] h_q;
  logic [11:0] v_q;
  logic [11:0] v_nxt;
  logic        h_wrap;
  logic        h_blank;
  logic        vb_cur;
  logic        vb_nxt;
  logic [3:0]  fvht;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      h_q <= '0;
      v_q <= '0;
    end else if (cen_i) begin
      h_q <= h_wrap ? 12'd0 : h_q + 12'd1;
      if (h_wrap) v_q <= v_nxt;
    end
  end

  // v switches at EAV to the state of the line that follows.
  always_comb begin
    h_wrap  = (h_q == HT1);
    v_nxt   = (v_q == VT1) ? 12'd0 : v_q + 12'd1;
    h_blank = (h_q >= HA);
    vb_cur  = (v_q < VS) || (v_q >= VE);
    vb_nxt  = (v_nxt < VS) || (v_nxt >= VE);
    fvht        = '0;
    fvht[V_BIT] = h_blank ? vb_nxt : vb_cur;
    fvht[H_BIT] = h_blank;
    fvht[T_BIT] = (h_blank && h_q <= EAV_END)
               || (h_q >= SAV_BEG);
  end

  assign tim.h_cnt       = h_q;
  assign tim.active      = !h_blank && !vb_cur;
  assign tim.frame_start = (h_q == 12'd0) && (v_q == 12'd0);
  assign tim.sof         = (h_q == 12'd0) && (v_q == VS);
  assign tim.fvht        = fvht;

endmodule

// File: rtl/video_pattern_gen.sv
// Test pattern source: bars, flat colour or luma ramp on a
// progressive raster, registered {Y,C} + fvht + sof outputs.
module video_pattern_gen
  import video_pkg::*;
#(
  parameter int H_ACTIVE = 1920,
  parameter int H_TOTAL  = 2200,
  parameter int V_TOTAL  = 1125,
  parameter int V_START  = 41,
  parameter int V_ACTIVE = 1080
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        cen_i,
  input  logic [1:0]  pat_sel_i,
  input  logic [2:0]  colour_idx_i,
  output logic [3:0]  fvht_o,
  output logic [19:0] video_o,
  output logic        sof_o
);

  localparam int BAR_W = H_ACTIVE / 8;

  video_timing_if tim ();

  video_timing_cnt #(
    .H_ACTIVE (H_ACTIVE),
    .H_TOTAL  (H_TOTAL),
    .V_TOTAL  (V_TOTAL),
    .V_START  (V_START),
    .V_ACTIVE (V_ACTIVE)
  ) u_cnt (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .cen_i   (cen_i),
    .tim     (tim)
  );

  pat_sel_e    pat_q;
  logic [2:0]  cidx_q;
  logic [2:0]  bar_idx;
  logic [2:0]  lut_idx;
  logic [10:0] ramp_sum;
  logic        is_blank;
  logic        is_ramp;
  logic        is_lut;
  logic [9:0]  y_d;
  logic [9:0]  c_d;

  // Selects only move at (0,0) so a frame never mixes patterns.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      pat_q  <= PAT_BARS;
      cidx_q <= '0;
    end else if (cen_i && tim.frame_start) begin
      pat_q  <= decode_pat(pat_sel_i);
      cidx_q <= colour_idx_i;
    end
  end

  always_comb begin
    bar_idx = '0;
    for (int k = 1; k < 8; k++) begin
      if (tim.h_cnt >= 12'(k * BAR_W)) bar_idx = 3'(k);
    end
    lut_idx  = (pat_q == PAT_FLAT) ? cidx_q : bar_idx;
    ramp_sum = 11'd64 + tim.h_cnt[11:1];
    is_blank = !tim.active;
    is_ramp  = tim.active && (pat_q == PAT_RAMP);
    is_lut   = tim.active && (pat_q != PAT_RAMP);
    y_d = Y_BLANK;
    c_d = C_BLANK;
    unique case (1'b1)
      is_blank: begin
        y_d = Y_BLANK;
        c_d = C_BLANK;
      end
      is_ramp: begin
        y_d = (ramp_sum > RAMP_MAX) ? RAMP_MAX[9:0]
                                    : ramp_sum[9:0];
      end
      is_lut: begin
        y_d = Y_LUT[lut_idx];
        c_d = tim.h_cnt[0] ? CR_LUT[lut_idx]
                           : CB_LUT[lut_idx];
      end
      default: begin
        y_d = Y_BLANK;
        c_d = C_BLANK;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      fvht_o  <= 4'b0110;
      video_o <= {Y_BLANK, C_BLANK};
      sof_o   <= 1'b0;
    end else if (cen_i) begin
      fvht_o  <= tim.fvht;
      video_o <= {y_d, c_d};
      sof_o   <= tim.sof;
    end
  end

endmodule

// File: tb/tb_video_pattern_gen.sv
// Directed bench for video_pattern_gen on a shortened frame
// (8 lines, active lines 2..6) with full-width lines.
module tb_video_pattern_gen;

  localparam int HA = 1920;
  localparam int HT = 2200;
  localparam int VT = 8;
  localparam int VS = 2;
  localparam int VA = 5;

  logic        clk_i = 1'b0;
  logic        rst_n_i = 1'b0;
  logic        cen_i = 1'b0;
  logic [1:0]  pat_sel_i = 2'd0;
  logic [2:0]  colour_idx_i = 3'd0;
  logic [3:0]  fvht_o;
  logic [19:0] video_o;
  logic        sof_o;

  int n_cmp = 0;
  int n_err = 0;
  int nxt_h = 0;
  int nxt_v = 0;
  int cur_h = -1;
  int cur_v = -1;
  int falls = 0;
  int vzero = 0;
  int thigh = 0;
  int sofs  = 0;
  int found;
  logic prev_h = 1'b1;
  logic [19:0] exp_vid;

  video_timing_if ref_if ();

  always #5 clk_i = ~clk_i;

  video_pattern_gen #(
    .H_ACTIVE (HA),
    .H_TOTAL  (HT),
    .V_TOTAL  (VT),
    .V_START  (VS),
    .V_ACTIVE (VA)
  ) dut (
    .clk_i        (clk_i),
    .rst_n_i      (rst_n_i),
    .cen_i        (cen_i),
    .pat_sel_i    (pat_sel_i),
    .colour_idx_i (colour_idx_i),
    .fvht_o       (fvht_o),
    .video_o      (video_o),
    .sof_o        (sof_o)
  );

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d",
               tag, got, exp);
    end
  endtask

  function automatic logic vblank(input int v);
    return (v < VS) || (v >= VS + VA);
  endfunction

  function automatic int ramp_y(input int h);
    int y;
    y = 64 + h / 2;
    return (y > 940) ? 940 : y;
  endfunction

  task automatic adv_c(input logic c);
    int vn;
    cen_i = c;
    @(posedge clk_i);
    #1;
    if (c) begin
      cur_h = nxt_h;
      cur_v = nxt_v;
      if (nxt_h == HT - 1) begin
        nxt_h = 0;
        nxt_v = (nxt_v == VT - 1) ? 0 : nxt_v + 1;
      end else begin
        nxt_h++;
      end
      vn = (cur_v == VT - 1) ? 0 : cur_v + 1;
      ref_if.h_cnt  = 12'(cur_h);
      ref_if.active = (cur_h < HA) && !vblank(cur_v);
      ref_if.sof    = (cur_h == 0) && (cur_v == VS);
      ref_if.frame_start = (cur_h == 0) && (cur_v == 0);
      ref_if.fvht = {1'b0,
        (cur_h >= HA) ? vblank(vn) : vblank(cur_v),
        cur_h >= HA,
        (cur_h >= HA && cur_h <= HA + 3) || cur_h >= HT - 4};
      if (prev_h && !fvht_o[1]) falls++;
      prev_h = fvht_o[1];
      if (!fvht_o[2]) vzero++;
      if (fvht_o[0]) thigh++;
      if (sof_o) sofs++;
      if (ref_if.frame_start) begin
        chk("fs_fvht", 32'(fvht_o), 32'(4'b0100));
        chk("fs_video", 32'(video_o), {12'd0, 10'd64, 10'd512});
      end
    end
  endtask

  task automatic run_to(input int h, input int v);
    int i;
    i = 0;
    while (!(cur_h == h && cur_v == v) && i < 2 * HT * VT) begin
      adv_c(1'b1);
      i++;
    end
    chk("run_to", 32'(cur_h == h && cur_v == v), 32'd1);
  endtask

  task automatic chk_tog();
    exp_vid = ref_if.active
            ? {10'(ramp_y(int'(ref_if.h_cnt))), 10'd512}
            : {10'd64, 10'd512};
    chk("tog_fvht", 32'(fvht_o), 32'(ref_if.fvht));
    chk("tog_sof", 32'(sof_o), 32'(ref_if.sof));
    chk("tog_video", 32'(video_o), 32'(exp_vid));
  endtask

  initial begin
    repeat (2) @(posedge clk_i);
    #1;
    chk("rst_fvht", 32'(fvht_o), 32'(4'b0110));
    chk("rst_video", 32'(video_o), {12'd0, 10'd64, 10'd512});
    chk("rst_sof", 32'(sof_o), 32'd0);
    @(negedge clk_i);
    rst_n_i = 1'b1;

    run_to(0, 0);
    chk("first_fvht", 32'(fvht_o), 32'(4'b0100));
    run_to(0, VS);
    chk("bar0_y", 32'(video_o[19:10]), 32'd940);
    chk("bar0_c", 32'(video_o[9:0]), 32'd512);
    chk("bar0_fvht", 32'(fvht_o), 32'(4'b0000));
    chk("bar0_sof", 32'(sof_o), 32'd1);
    run_to(240, VS);
    chk("bar240_y", 32'(video_o[19:10]), 32'd646);
    chk("bar240_cb", 32'(video_o[9:0]), 32'd176);
    run_to(241, VS);
    chk("bar241_y", 32'(video_o[19:10]), 32'd646);
    chk("bar241_cr", 32'(video_o[9:0]), 32'd567);
    run_to(1919, VS);
    chk("bar1919_y", 32'(video_o[19:10]), 32'd64);
    chk("bar1919_c", 32'(video_o[9:0]), 32'd512);
    chk("bar1919_sof", 32'(sof_o), 32'd0);
    run_to(1920, VS);
    chk("eav_video", 32'(video_o), {12'd0, 10'd64, 10'd512});
    chk("eav_fvht", 32'(fvht_o), 32'(4'b0011));

    run_to(0, 4);
    pat_sel_i = 2'd1;
    colour_idx_i = 3'd5;
    run_to(240, 5);
    chk("bars_hold_y", 32'(video_o[19:10]), 32'd646);
    run_to(HT - 1, VT - 1);
    chk("wrap_v", 32'(fvht_o[2]), 32'd1);
    chk("h_falls", 32'(falls), 32'(VT));
    chk("v_zero", 32'(vzero), 32'(VA * HT));
    chk("t_high", 32'(thigh), 32'(8 * VT));
    chk("sof_count", 32'(sofs), 32'd1);

    run_to(0, VS);
    chk("flat0_y", 32'(video_o[19:10]), 32'd260);
    chk("flat0_cb", 32'(video_o[9:0]), 32'd399);
    run_to(1, VS);
    chk("flat1_cr", 32'(video_o[9:0]), 32'd848);
    run_to(1000, VS);
    chk("flat1000_y", 32'(video_o[19:10]), 32'd260);
    chk("flat1000_cb", 32'(video_o[9:0]), 32'd399);
    run_to(0, 4);
    pat_sel_i = 2'd2;

    run_to(0, VS);
    chk("ramp0_y", 32'(video_o[19:10]), 32'd64);
    run_to(100, VS);
    chk("ramp100_y", 32'(video_o[19:10]), 32'd114);
    chk("ramp100_c", 32'(video_o[9:0]), 32'd512);
    run_to(1751, VS);
    chk("ramp1751_y", 32'(video_o[19:10]), 32'd939);

    for (int i = 0; i < 200; i++) begin
      adv_c(1'b1);
      chk_tog();
      adv_c(1'b0);
      chk_tog();
    end
    chk("tog_pos", 32'(cur_h), 32'd1951);

    run_to(1000, 4);
    #3;
    rst_n_i = 1'b0;
    #1;
    chk("arst_fvht", 32'(fvht_o), 32'(4'b0110));
    chk("arst_video", 32'(video_o), {12'd0, 10'd64, 10'd512});
    chk("arst_sof", 32'(sof_o), 32'd0);
    pat_sel_i = 2'd3;
    @(posedge clk_i);
    @(posedge clk_i);
    #2;
    rst_n_i = 1'b1;
    nxt_h = 0;
    nxt_v = 0;
    cur_h = -1;
    cur_v = -1;
    found = -1;
    for (int i = 0; i < 3 * VS * HT; i++) begin
      adv_c(1'b1);
      if (sof_o) begin
        found = i;
        break;
      end
    end
    chk("sof_after_rst", 32'(found), 32'(VS * HT));
    chk("sel3_bars_y", 32'(video_o[19:10]), 32'd940);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
